input_conditioner: RTL and testbench

INPUT_CONDITIONER -- requirements
Module: input_conditioner

---
 rtl/input_conditioner.sv | 109 ++++++++++
 tb/tb_input_conditioner.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/input_conditioner.sv
// input_conditioner: synchronises and debounces active-low push buttons and
// active-high slide switches, producing registered levels and optional
// one-cycle edge pulses.
// Optional feature macro: INPUT_COND_EDGE_EN enables btn_press, btn_release
// and sw_change; without it those outputs are tied to zero.
module input_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_250_000,
    parameter int unsigned NUM_BTN         = 3,
    parameter int unsigned NUM_SW          = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] btn_raw,
    input  logic [NUM_SW-1:0]  sw_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_SW-1:0]  sw_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release,
    output logic [NUM_SW-1:0]  sw_change
);

    // Buttons and switches share one datapath: buttons occupy the upper bits.
    localparam int unsigned     NUM_IN   = NUM_BTN + NUM_SW;
    localparam int unsigned     CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [NUM_IN-1:0] RST_VAL = {{NUM_BTN{1'b1}}, {NUM_SW{1'b0}}};

    logic [NUM_IN-1:0] raw;
    logic [NUM_IN-1:0] s1;
    logic [NUM_IN-1:0] s2;
    logic [NUM_IN-1:0] db;
    logic [NUM_IN-1:0] lvl;
    logic [CNT_W-1:0]  cnt [NUM_IN];

    assign raw = {btn_raw, sw_raw};

    // Two-flop synchroniser; raw inputs feed nothing else.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= RST_VAL;
            s2 <= RST_VAL;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    // Per-bit debouncer: accept s2 after DEBOUNCE_CYCLES consecutive differing edges.
    always_ff @(posedge clk) begin
        if (reset) begin
            db <= RST_VAL;
            for (int unsigned i = 0; i < NUM_IN; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_IN; i++) begin
                if (s2[i] == db[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    db[i]  <= s2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Output level register; pulses are derived from the same db/lvl pair so
    // they line up with the first cycle the level shows the new value.
    always_ff @(posedge clk) begin
        if (reset) begin
            lvl <= RST_VAL;
        end else begin
            lvl <= db;
        end
    end

    assign btn_level = lvl[NUM_IN-1 -: NUM_BTN];
    assign sw_level  = lvl[NUM_SW-1:0];

`ifdef INPUT_COND_EDGE_EN
    logic [NUM_IN-1:0] fall;
    logic [NUM_IN-1:0] rise;
    logic [NUM_IN-1:0] flip;

    assign fall = lvl & ~db;
    assign rise = ~lvl & db;
    assign flip = lvl ^ db;

    // Registered one-cycle edge pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            btn_press   <= '0;
            btn_release <= '0;
            sw_change   <= '0;
        end else begin
            btn_press   <= fall[NUM_IN-1 -: NUM_BTN];
            btn_release <= rise[NUM_IN-1 -: NUM_BTN];
            sw_change   <= flip[NUM_SW-1:0];
        end
    end
`else
    assign btn_press   = '0;
    assign btn_release = '0;
    assign sw_change   = '0;
`endif

endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner: directed and random stimulus checked against a
// window-based reference model (a change is accepted once the last D
// synchronised samples all disagree with the accepted value).
module tb_input_conditioner;

    localparam int unsigned D = 4;

    logic       clk;
    logic       reset;
    logic [2:0] btn_raw;
    logic [9:0] sw_raw;
    logic [2:0] btn_level;
    logic [9:0] sw_level;
    logic [2:0] btn_press;
    logic [2:0] btn_release;
    logic [9:0] sw_change;

    input_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .NUM_BTN        (3),
        .NUM_SW         (10)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_raw    (btn_raw),
        .sw_raw     (sw_raw),
        .btn_level  (btn_level),
        .sw_level   (sw_level),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .sw_change  (sw_change)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [12:0] RV = 13'b111_0000000000;

    int unsigned total;
    int unsigned passed;

    // Reference model: hw[0] is the newest synchroniser input sample.
    logic [12:0] hw [0:D];
    logic [12:0] m_db;
    logic [12:0] m_lvl;
    logic [12:0] m_fall;
    logic [12:0] m_rise;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_edge(input logic r, input logic [12:0] x);
        logic [12:0] acc;
        if (r) begin
            for (int k = 0; k <= D; k++) hw[k] = RV;
            m_db   = RV;
            m_lvl  = RV;
            m_fall = '0;
            m_rise = '0;
        end else begin
            acc = '0;
            for (int i = 0; i < 13; i++) begin
                acc[i] = 1'b1;
                for (int k = 1; k <= D; k++)
                    if (hw[k][i] == m_db[i]) acc[i] = 1'b0;
            end
            m_fall = m_lvl & ~m_db;
            m_rise = ~m_lvl & m_db;
            m_lvl  = m_db;
            m_db   = m_db ^ acc;
            for (int k = D; k >= 1; k--) hw[k] = hw[k-1];
            hw[0] = x;
        end
    endtask

    // One clock: drive, advance, update model, compare every output.
    task automatic step(input logic [2:0] b, input logic [9:0] s, input logic r);
        logic [12:0] flip;
        logic [12:0] e_press;
        logic [12:0] e_rel;
        logic [12:0] e_chg;
        btn_raw = b;
        sw_raw  = s;
        reset   = r;
        @(posedge clk);
        model_edge(r, {b, s});
        #1;
        flip = m_fall | m_rise;
`ifdef INPUT_COND_EDGE_EN
        e_press = {10'b0, m_fall[12:10]};
        e_rel   = {10'b0, m_rise[12:10]};
        e_chg   = {3'b0, flip[9:0]};
`else
        e_press = '0;
        e_rel   = '0;
        e_chg   = '0;
`endif
        chk("btn_level",   {29'b0, btn_level},   {29'b0, m_lvl[12:10]});
        chk("sw_level",    {22'b0, sw_level},    {22'b0, m_lvl[9:0]});
        chk("btn_press",   {29'b0, btn_press},   {19'b0, e_press});
        chk("btn_release", {29'b0, btn_release}, {19'b0, e_rel});
        chk("sw_change",   {22'b0, sw_change},   {19'b0, e_chg});
    endtask

    // Holds inputs and measures the edge index (0 = first s1 sample) at which
    // output bit idx of {btn_level, sw_level} reaches val; bounded at 20.
    task automatic lat_run(input string tag, input logic [2:0] b, input logic [9:0] s,
                           input int idx, input logic val, input int exp_lat);
        int lat;
        logic [12:0] o;
        lat = -1;
        for (int j = 0; j < 20; j++) begin
            step(b, s, 1'b0);
            o = {btn_level, sw_level};
            if (lat < 0 && o[idx] == val) lat = j;
        end
        chk(tag, 32'(lat), 32'(exp_lat));
    endtask

    initial begin
        logic [2:0] cb;
        logic [9:0] cs;
        logic [12:0] cur;
        logic [12:0] mask;
        int unsigned len;

        total  = 0;
        passed = 0;
        for (int k = 0; k <= D; k++) hw[k] = RV;
        m_db = RV; m_lvl = RV; m_fall = '0; m_rise = '0;
        btn_raw = 3'b111; sw_raw = '0; reset = 1'b1;

        // Reset and quiet period.
        step(3'b111, 10'h000, 1'b1);
        step(3'b111, 10'h000, 1'b1);
        chk("rst_btn_level", {29'b0, btn_level}, 32'h7);
        chk("rst_sw_level",  {22'b0, sw_level},  32'h0);
        for (int j = 0; j < 20; j++) step(3'b111, 10'h000, 1'b0);

        // Clean press on button 1.
        lat_run("lat_btn1_press", 3'b101, 10'h000, 11, 1'b0, 6);
        for (int j = 0; j < 10; j++) step(3'b111, 10'h000, 1'b0);

        // Bounce shorter than D on button 0, then a held press.
        for (int j = 0; j < 3; j++) step(3'b110, 10'h000, 1'b0);
        for (int j = 0; j < 6; j++) step(3'b111, 10'h000, 1'b0);
        chk("bounce_no_change", {29'b0, btn_level}, 32'h7);
        lat_run("lat_btn0_press", 3'b110, 10'h000, 10, 1'b0, 6);
        for (int j = 0; j < 10; j++) step(3'b111, 10'h000, 1'b0);

        // All switches change together.
        lat_run("lat_sw_all", 3'b111, 10'h3FF, 0, 1'b1, 6);
        chk("sw_all_level", {22'b0, sw_level}, 32'h3FF);
        for (int j = 0; j < 10; j++) step(3'b111, 10'h000, 1'b0);

        // Reset mid-count on button 2 discards progress.
        for (int j = 0; j < 3; j++) step(3'b011, 10'h000, 1'b0);
        step(3'b011, 10'h000, 1'b1);
        chk("mid_rst_btn_level", {29'b0, btn_level}, 32'h7);
        lat_run("lat_btn2_after_rst", 3'b011, 10'h000, 12, 1'b0, 6);

        // Random segments with occasional reset.
        cur = {3'b011, 10'h000};
        for (int seg = 0; seg < 600; seg++) begin
            mask = 13'($urandom & $urandom);
            cur  = cur ^ mask;
            cb   = cur[12:10];
            cs   = cur[9:0];
            len  = $urandom_range(1, 8);
            if ($urandom_range(0, 49) == 0) step(cb, cs, 1'b1);
            for (int unsigned j = 0; j < len; j++) step(cb, cs, 1'b0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
